// File: rtl/tm_pkg.sv
// Shared definitions for Tsetlin Machine inference blocks: default sizes,
// literal-bit encoding inside an exclude word, sequencer states and vote width.
package tm_pkg;

  localparam int DEF_NUM_FEATURES = 784;
  localparam int DEF_NUM_CLAUSES  = 20;

  // Position of each literal's exclude bit inside its 2-bit feature slot.
  localparam int LIT_POS = 0;
  localparam int LIT_NEG = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Signed width that holds -NC/2 .. +NC/2.
  function automatic int vote_width(input int num_clauses);
    return $clog2(num_clauses / 2 + 1) + 1;
  endfunction

endpackage

// File: rtl/tm_clause_eval.sv
// Combinational single-clause evaluator: a clause is the AND of every literal
// not excluded by its exclude word; an all-excluded clause evaluates to 1.
module tm_clause_eval
  import tm_pkg::*;
#(
  parameter int NUM_FEATURES = DEF_NUM_FEATURES
) (
  input  logic [NUM_FEATURES-1:0]   features,
  input  logic [2*NUM_FEATURES-1:0] exclude,
  output logic                      clause_out
);

  logic [NUM_FEATURES-1:0] lit_ok;

  always_comb begin
    lit_ok = '0;
    for (int k = 0; k < NUM_FEATURES; k++) begin
      lit_ok[k] = (exclude[2*k+LIT_POS] |  features[k]) &
                  (exclude[2*k+LIT_NEG] | ~features[k]);
    end
  end

  assign clause_out = &lit_ok;

endmodule

// File: rtl/tm_clause_sequencer.sv
// Time-multiplexed Tsetlin Machine inference: fetches one exclude word per
// cycle from clause RAM, scores it one cycle later and accumulates the votes.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | start_ready=1, waiting for a sample
//  ST_FETCH | issuing clause reads 0..NC-1, scoring the previous read
//  ST_DRAIN | no read; scoring the last clause, registering the result
//  ST_DONE  | result_valid=1, held until result_ready
module tm_clause_sequencer
  import tm_pkg::*;
#(
  parameter int        NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int        NUM_CLAUSES  = DEF_NUM_CLAUSES,
  parameter int signed THRESHOLD    = 0,
  localparam int       CW           = $clog2(NUM_CLAUSES),
  localparam int       VW           = vote_width(NUM_CLAUSES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [NUM_FEATURES-1:0]   features,
  output logic                      mem_rd_en,
  output logic [CW-1:0]             mem_addr,
  input  logic [2*NUM_FEATURES-1:0] mem_rd_data,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic                      verdict,
  output logic signed [VW-1:0]      vote_sum
);

  seq_state_e              state, state_nxt;
  logic [NUM_FEATURES-1:0] feat_q;
  logic [CW-1:0]           addr_q;
  logic [CW-1:0]           eval_idx_q;
  logic                    eval_vld_q;
  logic signed [VW-1:0]    acc_q;
  logic signed [VW-1:0]    acc_nxt;
  logic signed [VW-1:0]    vote_delta;
  logic                    clause_hit;
  logic                    accept;
  logic                    last_fetch;

  tm_clause_eval #(
    .NUM_FEATURES (NUM_FEATURES)
  ) u_clause_eval (
    .features   (feat_q),
    .exclude    (mem_rd_data),
    .clause_out (clause_hit)
  );

  assign last_fetch = (addr_q == CW'(NUM_CLAUSES - 1));
  assign accept     = start_valid & start_ready;
  assign mem_addr   = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_ready  = 1'b0;
    mem_rd_en    = 1'b0;
    result_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd_en = 1'b1;
        if (last_fetch) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Lower half of the clause bank votes for the class, upper half against.
  always_comb begin
    vote_delta = '0;
    if (eval_vld_q && clause_hit) begin
      vote_delta = (eval_idx_q < CW'(NUM_CLAUSES / 2)) ? VW'(1) : '1;
    end
    acc_nxt = acc_q + vote_delta;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q     <= '0;
      addr_q     <= '0;
      eval_idx_q <= '0;
      eval_vld_q <= 1'b0;
      acc_q      <= '0;
      vote_sum   <= '0;
      verdict    <= 1'b0;
    end else begin
      eval_vld_q <= mem_rd_en;
      eval_idx_q <= addr_q;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            feat_q <= features;
            addr_q <= '0;
            acc_q  <= '0;
          end
        end
        ST_FETCH: begin
          addr_q <= last_fetch ? '0 : addr_q + CW'(1);
          acc_q  <= acc_nxt;
        end
        ST_DRAIN: begin
          acc_q    <= acc_nxt;
          vote_sum <= acc_nxt;
          verdict  <= (int'(acc_nxt) >= THRESHOLD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_clause_sequencer.sv
// Bench for tm_clause_sequencer: small directed/random configurations plus a
// full-size random run, all scored against a clause-by-clause reference model.
module tb_tm_clause_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Small configuration (NF=4, NC=4), THRESHOLD=0 (_s) and THRESHOLD=3 (_t)
  logic              start_valid_s, result_ready_s;
  logic [3:0]        features_s;
  logic [7:0]        rd_data_s, rd_data_t;
  logic              start_ready_s, rd_en_s, result_valid_s, verdict_s;
  logic [1:0]        addr_s;
  logic signed [2:0] vote_s;
  logic              start_ready_t, rd_en_t, result_valid_t, verdict_t;
  logic [1:0]        addr_t;
  logic signed [2:0] vote_t;

  // Full-size configuration (NF=784, NC=20)
  logic              start_valid_b, result_ready_b;
  logic [783:0]      features_b;
  logic [1567:0]     rd_data_b;
  logic              start_ready_b, rd_en_b, result_valid_b, verdict_b;
  logic [4:0]        addr_b;
  logic signed [4:0] vote_b;

  logic [7:0]    ram_s [0:3];
  logic [1567:0] ram_b [0:19];

  tm_clause_sequencer #(.NUM_FEATURES(4), .NUM_CLAUSES(4), .THRESHOLD(0)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid_s), .start_ready(start_ready_s),
    .features(features_s), .mem_rd_en(rd_en_s), .mem_addr(addr_s), .mem_rd_data(rd_data_s),
    .result_valid(result_valid_s), .result_ready(result_ready_s), .verdict(verdict_s),
    .vote_sum(vote_s));

  tm_clause_sequencer #(.NUM_FEATURES(4), .NUM_CLAUSES(4), .THRESHOLD(3)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid_s), .start_ready(start_ready_t),
    .features(features_s), .mem_rd_en(rd_en_t), .mem_addr(addr_t), .mem_rd_data(rd_data_t),
    .result_valid(result_valid_t), .result_ready(result_ready_s), .verdict(verdict_t),
    .vote_sum(vote_t));

  tm_clause_sequencer #(.NUM_FEATURES(784), .NUM_CLAUSES(20), .THRESHOLD(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid_b), .start_ready(start_ready_b),
    .features(features_b), .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rd_data_b),
    .result_valid(result_valid_b), .result_ready(result_ready_b), .verdict(verdict_b),
    .vote_sum(vote_b));

  // Clause RAMs: 1-cycle read latency, junk on the bus when not read.
  always @(posedge clk) begin
    rd_data_s <= rd_en_s ? ram_s[addr_s] : 8'($urandom);
    rd_data_t <= rd_en_t ? ram_s[addr_t] : 8'($urandom);
    rd_data_b <= rd_en_b ? ram_b[addr_b] : '1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: evaluate each clause literal by literal and tally the votes.
  function automatic int model_sum(input bit big, input logic [783:0] x);
    int nf = big ? 784 : 4;
    int nc = big ? 20 : 4;
    int s  = 0;
    for (int c = 0; c < nc; c++) begin
      logic [1567:0] w;
      bit cl;
      w  = big ? ram_b[c] : {1560'b0, ram_s[c]};
      cl = 1'b1;
      for (int k = 0; k < nf; k++) begin
        if (!w[2*k]   && !x[k]) cl = 1'b0;
        if (!w[2*k+1] &&  x[k]) cl = 1'b0;
      end
      if (cl) s += (c < nc / 2) ? 1 : -1;
    end
    return s;
  endfunction

  task automatic do_sample(input logic [3:0] feat, input int hold);
    int lat;
    int exp_sum;
    int addr_q[$];
    bit stable;
    logic signed [2:0] vote0;
    @(negedge clk);
    features_s    = feat;
    start_valid_s = 1'b1;
    lat = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start_valid_s = 1'b0;
        features_s    = 4'($urandom);
      end
      if (rd_en_s) addr_q.push_back(int'(addr_s));
      if (result_valid_s) begin
        lat = j;
        break;
      end
    end
    exp_sum = model_sum(1'b0, {780'b0, feat});
    check("latency", lat, 6);
    check("vote_sum", vote_s, exp_sum);
    check("verdict", verdict_s, int'(exp_sum >= 0));
    check("vote_sum_thr3", vote_t, exp_sum);
    check("verdict_thr3", verdict_t, int'(exp_sum >= 3));
    check("addr_count", addr_q.size(), 4);
    foreach (addr_q[i]) check("addr_seq", addr_q[i], i);
    if (hold > 0) begin
      vote0  = vote_s;
      stable = 1'b1;
      start_valid_s = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!result_valid_s || vote_s !== vote0 || start_ready_s || rd_en_s) stable = 1'b0;
      end
      check("hold_stable", stable, 1);
      check("hold_vote", vote_s, exp_sum);
      start_valid_s = 1'b0;
    end
    result_ready_s = 1'b1;
    @(negedge clk);
    check("back_to_idle", start_ready_s, 1);
    check("result_dropped", result_valid_s, 0);
    check("no_read_in_idle", rd_en_s, 0);
    result_ready_s = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int to;
    int exp_sum;
    logic [783:0] fx;
    rst_n = 1'b0;
    start_valid_s = 1'b0; result_ready_s = 1'b0; features_s = '0;
    start_valid_b = 1'b0; result_ready_b = 1'b1; features_b = '0;
    for (int c = 0; c < 4; c++)  ram_s[c] = 8'hFF;
    for (int c = 0; c < 20; c++) ram_b[c] = '1;
    repeat (3) @(negedge clk);
    check("rst_rd_en", rd_en_s, 0);
    check("rst_result_valid", result_valid_s, 0);
    check("rst_mem_addr", addr_s, 0);
    check("rst_vote_sum", vote_s, 0);
    check("rst_verdict", verdict_s, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_start_ready", start_ready_s, 1);

    // All clauses excluded everywhere: every clause fires, votes cancel.
    do_sample(4'b1010, 0);

    // Negative clauses require x0, features all zero: only positives fire.
    ram_s[0] = 8'hFF; ram_s[1] = 8'hFF; ram_s[2] = 8'hFE; ram_s[3] = 8'hFE;
    do_sample(4'b0000, 10);

    // Positive clauses require x1 & ~x1: only negatives fire.
    ram_s[0] = 8'hF3; ram_s[1] = 8'hF3; ram_s[2] = 8'hFF; ram_s[3] = 8'hFF;
    do_sample(4'b0110, 0);

    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4; c++) begin
        ram_s[c] = 8'hFF;
        repeat ($urandom_range(0, 2)) ram_s[c][$urandom_range(0, 7)] = 1'b0;
      end
      do_sample(4'($urandom), r % 3);
    end

    // Reset in the middle of the fetch phase.
    ram_s[0] = 8'hFF; ram_s[1] = 8'hFF; ram_s[2] = 8'hFE; ram_s[3] = 8'hFE;
    @(negedge clk);
    features_s = 4'b0000; start_valid_s = 1'b1;
    @(negedge clk);
    start_valid_s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_en", rd_en_s, 0);
    check("midrst_result_valid", result_valid_s, 0);
    check("midrst_mem_addr", addr_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_start_ready", start_ready_s, 1);
    ram_s[0] = 8'hFE; ram_s[1] = 8'hFF; ram_s[2] = 8'hFF; ram_s[3] = 8'hFB;
    do_sample(4'b0011, 0);

    // Full-size back-to-back random samples.
    for (int s = 0; s < 1000; s++) begin
      for (int c = 0; c < 20; c++) begin
        ram_b[c] = '1;
        repeat ($urandom_range(0, 2)) ram_b[c][$urandom_range(0, 1567)] = 1'b0;
      end
      for (int i = 0; i < 784; i++) fx[i] = 1'($urandom_range(0, 1));
      features_b    = fx;
      start_valid_b = 1'b1;
      exp_sum = model_sum(1'b1, fx);
      to = 0;
      while (!start_ready_b && to < 5) begin
        @(negedge clk);
        to++;
      end
      @(negedge clk);
      start_valid_b = 1'b0;
      features_b    = ~fx;
      lat = 1;
      while (!result_valid_b && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("big_latency", lat, 22);
      check("big_vote_sum", vote_b, exp_sum);
      check("big_verdict", verdict_b, int'(exp_sum >= 0));
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
